nat_table_arbiter: RTL and testbench

Owns the NAT connection table and sequences every access to it. It clears the table after reset, then arbitrates between two requesters. The packet-path lookup engine sends 5-tuple lookup/insert requests, and the host management port sends slot read and delete requests. It sits between the header-parsing stage and the table storage, replacing direct table access from the packet path.

---
 rtl/nat_pkg.sv | 29 ++
 rtl/conn_table_ram.sv | 23 ++
 rtl/nat_table_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_nat_table_arbiter.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nat_pkg.sv
// Shared types and defaults for the NAT connection table arbiter.
// Slot state encoding, FSM states, grant owner and management opcodes.
package nat_pkg;

  localparam int HASH_LEN_DEF  = 6;
  localparam int KEY_WIDTH_DEF = 104;

  typedef enum logic [1:0] {
    SLOT_EMPTY = 2'b00,
    SLOT_VALID = 2'b01,
    SLOT_TOMB  = 2'b10
  } slot_st_e;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_PROBE,
    ST_MGMT
  } fsm_e;

  typedef enum logic {
    GRANT_LK = 1'b0,
    GRANT_MG = 1'b1
  } grant_e;

  localparam logic MG_OP_READ   = 1'b0;
  localparam logic MG_OP_DELETE = 1'b1;

endpackage

// File: rtl/conn_table_ram.sv
// Connection table storage: combinational read, synchronous write.
// The array has no reset; the arbiter's INIT sweep clears it.
module conn_table_ram #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 106
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/nat_table_arbiter.sv
// NAT table owner: clears the table after reset, then serves packet-path
// lookup/insert (linear probing with tombstone reuse) and host read/delete.
module nat_table_arbiter
  import nat_pkg::*;
#(
  parameter int HASH_LEN  = HASH_LEN_DEF,
  parameter int KEY_WIDTH = KEY_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 lk_req_valid,
  output logic                 lk_req_ready,
  input  logic [KEY_WIDTH-1:0] lk_key,
  input  logic [HASH_LEN-1:0]  lk_hash,
  output logic                 lk_rsp_valid,
  output logic [HASH_LEN-1:0]  lk_rsp_idx,
  output logic                 lk_rsp_new,
  output logic                 lk_rsp_full,
  input  logic                 mg_req_valid,
  output logic                 mg_req_ready,
  input  logic                 mg_op,
  input  logic [HASH_LEN-1:0]  mg_addr,
  output logic                 mg_rsp_valid,
  output logic                 mg_rsp_hit,
  output logic [KEY_WIDTH-1:0] mg_rsp_key,
  output logic                 init_done
);

  localparam int SLOT_W = KEY_WIDTH + 2;

  fsm_e                 state_q, state_d;
  grant_e               last_grant_q, last_grant_d;
  logic [HASH_LEN-1:0]  addr_q, addr_d;
  logic [HASH_LEN-1:0]  cnt_q, cnt_d;
  logic [HASH_LEN-1:0]  tomb_addr_q, tomb_addr_d;
  logic                 tomb_v_q, tomb_v_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic                 op_q, op_d;
  logic                 init_done_q, init_done_d;
  logic                 lk_rsp_valid_q, lk_rsp_valid_d;
  logic [HASH_LEN-1:0]  lk_rsp_idx_q, lk_rsp_idx_d;
  logic                 lk_rsp_new_q, lk_rsp_new_d;
  logic                 lk_rsp_full_q, lk_rsp_full_d;
  logic                 mg_rsp_valid_q, mg_rsp_valid_d;
  logic                 mg_rsp_hit_q, mg_rsp_hit_d;
  logic [KEY_WIDTH-1:0] mg_rsp_key_q, mg_rsp_key_d;

  logic                 we;
  logic [HASH_LEN-1:0]  waddr;
  logic [SLOT_W-1:0]    wdata, rdata;
  logic [1:0]           rd_st;
  logic [KEY_WIDTH-1:0] rd_key;
  logic                 both_req, lk_win, mg_win;

  conn_table_ram #(
    .ADDR_W (HASH_LEN),
    .DATA_W (SLOT_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (addr_q),
    .rdata_o (rdata)
  );

  assign {rd_st, rd_key} = rdata;

  // The loser of a simultaneous request sees ready low; an idle port still sees ready.
  assign both_req     = lk_req_valid && mg_req_valid;
  assign lk_req_ready = (state_q == ST_IDLE) && !(both_req && last_grant_q == GRANT_LK);
  assign mg_req_ready = (state_q == ST_IDLE) && !(both_req && last_grant_q == GRANT_MG);
  assign lk_win       = lk_req_valid && lk_req_ready;
  assign mg_win       = mg_req_valid && mg_req_ready;

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    addr_d         = addr_q;
    cnt_d          = cnt_q;
    tomb_addr_d    = tomb_addr_q;
    tomb_v_d       = tomb_v_q;
    key_d          = key_q;
    op_d           = op_q;
    init_done_d    = init_done_q;
    lk_rsp_valid_d = 1'b0;
    lk_rsp_idx_d   = lk_rsp_idx_q;
    lk_rsp_new_d   = lk_rsp_new_q;
    lk_rsp_full_d  = lk_rsp_full_q;
    mg_rsp_valid_d = 1'b0;
    mg_rsp_hit_d   = mg_rsp_hit_q;
    mg_rsp_key_d   = mg_rsp_key_q;
    we             = 1'b0;
    waddr          = addr_q;
    wdata          = '0;
    unique case (state_q)
      ST_INIT: begin
        we     = 1'b1;
        wdata  = {SLOT_EMPTY, {KEY_WIDTH{1'b0}}};
        addr_d = addr_q + 1'b1;
        if (addr_q == '1) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
        end
      end
      ST_IDLE: begin
        if (lk_win) begin
          state_d      = ST_PROBE;
          last_grant_d = GRANT_LK;
          addr_d       = lk_hash;
          key_d        = lk_key;
          cnt_d        = '0;
          tomb_v_d     = 1'b0;
        end else if (mg_win) begin
          state_d      = ST_MGMT;
          last_grant_d = GRANT_MG;
          addr_d       = mg_addr;
          op_d         = mg_op;
        end
      end
      ST_PROBE: begin
        if (rd_st == SLOT_VALID && rd_key == key_q) begin
          state_d        = ST_IDLE;
          lk_rsp_valid_d = 1'b1;
          lk_rsp_idx_d   = addr_q;
          lk_rsp_new_d   = 1'b0;
          lk_rsp_full_d  = 1'b0;
        end else if (rd_st == SLOT_EMPTY) begin
          we             = 1'b1;
          waddr          = tomb_v_q ? tomb_addr_q : addr_q;
          wdata          = {SLOT_VALID, key_q};
          state_d        = ST_IDLE;
          lk_rsp_valid_d = 1'b1;
          lk_rsp_idx_d   = waddr;
          lk_rsp_new_d   = 1'b1;
          lk_rsp_full_d  = 1'b0;
        end else if (cnt_q == '1) begin
          // Whole table walked: a tombstone seen on this last probe still counts.
          state_d        = ST_IDLE;
          lk_rsp_valid_d = 1'b1;
          if (tomb_v_q || rd_st == SLOT_TOMB) begin
            we            = 1'b1;
            waddr         = tomb_v_q ? tomb_addr_q : addr_q;
            wdata         = {SLOT_VALID, key_q};
            lk_rsp_idx_d  = waddr;
            lk_rsp_new_d  = 1'b1;
            lk_rsp_full_d = 1'b0;
          end else begin
            lk_rsp_idx_d  = '0;
            lk_rsp_new_d  = 1'b0;
            lk_rsp_full_d = 1'b1;
          end
        end else begin
          if (rd_st == SLOT_TOMB && !tomb_v_q) begin
            tomb_v_d    = 1'b1;
            tomb_addr_d = addr_q;
          end
          addr_d = addr_q + 1'b1;
          cnt_d  = cnt_q + 1'b1;
        end
      end
      ST_MGMT: begin
        state_d        = ST_IDLE;
        mg_rsp_valid_d = 1'b1;
        mg_rsp_hit_d   = (rd_st == SLOT_VALID);
        mg_rsp_key_d   = (rd_st == SLOT_VALID) ? rd_key : '0;
        if (op_q == MG_OP_DELETE && rd_st == SLOT_VALID) begin
          we    = 1'b1;
          wdata = {SLOT_TOMB, rd_key};
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_INIT;
      last_grant_q   <= GRANT_MG;
      addr_q         <= '0;
      cnt_q          <= '0;
      tomb_v_q       <= 1'b0;
      op_q           <= 1'b0;
      init_done_q    <= 1'b0;
      lk_rsp_valid_q <= 1'b0;
      lk_rsp_idx_q   <= '0;
      lk_rsp_new_q   <= 1'b0;
      lk_rsp_full_q  <= 1'b0;
      mg_rsp_valid_q <= 1'b0;
      mg_rsp_hit_q   <= 1'b0;
      mg_rsp_key_q   <= '0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      addr_q         <= addr_d;
      cnt_q          <= cnt_d;
      tomb_v_q       <= tomb_v_d;
      op_q           <= op_d;
      init_done_q    <= init_done_d;
      lk_rsp_valid_q <= lk_rsp_valid_d;
      lk_rsp_idx_q   <= lk_rsp_idx_d;
      lk_rsp_new_q   <= lk_rsp_new_d;
      lk_rsp_full_q  <= lk_rsp_full_d;
      mg_rsp_valid_q <= mg_rsp_valid_d;
      mg_rsp_hit_q   <= mg_rsp_hit_d;
      mg_rsp_key_q   <= mg_rsp_key_d;
    end
  end

  // Probe key and tombstone address are only read while tomb_v/state say so.
  always_ff @(posedge clk) begin
    key_q       <= key_d;
    tomb_addr_q <= tomb_addr_d;
  end

  assign lk_rsp_valid = lk_rsp_valid_q;
  assign lk_rsp_idx   = lk_rsp_idx_q;
  assign lk_rsp_new   = lk_rsp_new_q;
  assign lk_rsp_full  = lk_rsp_full_q;
  assign mg_rsp_valid = mg_rsp_valid_q;
  assign mg_rsp_hit   = mg_rsp_hit_q;
  assign mg_rsp_key   = mg_rsp_key_q;
  assign init_done    = init_done_q;

endmodule

// File: tb/tb_nat_table_arbiter.sv
// Bench for nat_table_arbiter: scenario tasks checked against a
// behavioural hash-table model (linear probing with tombstone reuse).
module tb_nat_table_arbiter;

  localparam int HL = 6;
  localparam int KW = 104;
  localparam int N  = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          lk_req_valid = 1'b0;
  logic          lk_req_ready;
  logic [KW-1:0] lk_key = '0;
  logic [HL-1:0] lk_hash = '0;
  logic          lk_rsp_valid;
  logic [HL-1:0] lk_rsp_idx;
  logic          lk_rsp_new;
  logic          lk_rsp_full;
  logic          mg_req_valid = 1'b0;
  logic          mg_req_ready;
  logic          mg_op = 1'b0;
  logic [HL-1:0] mg_addr = '0;
  logic          mg_rsp_valid;
  logic          mg_rsp_hit;
  logic [KW-1:0] mg_rsp_key;
  logic          init_done;

  int checks = 0;
  int errors = 0;

  // Model: 0 = empty, 1 = holds a key, 2 = deleted
  int            m_st  [N];
  logic [KW-1:0] m_key [N];

  nat_table_arbiter #(.HASH_LEN(HL), .KEY_WIDTH(KW)) dut (
    .clk(clk), .reset(reset),
    .lk_req_valid(lk_req_valid), .lk_req_ready(lk_req_ready),
    .lk_key(lk_key), .lk_hash(lk_hash),
    .lk_rsp_valid(lk_rsp_valid), .lk_rsp_idx(lk_rsp_idx),
    .lk_rsp_new(lk_rsp_new), .lk_rsp_full(lk_rsp_full),
    .mg_req_valid(mg_req_valid), .mg_req_ready(mg_req_ready),
    .mg_op(mg_op), .mg_addr(mg_addr),
    .mg_rsp_valid(mg_rsp_valid), .mg_rsp_hit(mg_rsp_hit),
    .mg_rsp_key(mg_rsp_key), .init_done(init_done)
  );

  always #5 clk = ~clk;

  function automatic logic [KW-1:0] rand_key();
    return {$urandom, $urandom, $urandom, 8'($urandom)};
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < N; i++) begin
      m_st[i]  = 0;
      m_key[i] = '0;
    end
  endfunction

  task automatic model_lookup(input logic [KW-1:0] key, input int hash,
                              output int idx, output bit nw, output bit full, output int probes);
    int first;
    int a;
    bit done;
    first = -1; done = 0; idx = 0; nw = 0; full = 0; probes = N;
    for (int i = 0; i < N && !done; i++) begin
      a = (hash + i) % N;
      if (m_st[a] == 1 && m_key[a] == key) begin
        idx = a; probes = i + 1; done = 1;
      end else if (m_st[a] == 0) begin
        idx = (first >= 0) ? first : a; nw = 1; probes = i + 1; done = 1;
      end else if (m_st[a] == 2 && first < 0) begin
        first = a;
      end
    end
    if (!done) begin
      if (first >= 0) begin idx = first; nw = 1; end
      else full = 1;
    end
    if (nw) begin m_st[idx] = 1; m_key[idx] = key; end
  endtask

  task automatic model_mgmt(input bit op, input int addr, output bit hit, output logic [KW-1:0] key);
    hit = (m_st[addr] == 1);
    key = hit ? m_key[addr] : '0;
    if (op && hit) m_st[addr] = 2;
  endtask

  task automatic dut_lookup(input logic [KW-1:0] key, input logic [HL-1:0] hash,
                            output int idx, output bit nw, output bit full,
                            output int lat, output bit timeout);
    bit acc;
    bit seen;
    int g;
    acc = 0; seen = 0; g = 0; lat = 0; idx = 0; nw = 0; full = 0;
    @(negedge clk);
    lk_req_valid = 1'b1; lk_key = key; lk_hash = hash;
    while (!acc && g < 300) begin
      #1; acc = lk_req_ready;
      @(posedge clk); g++;
      if (!acc) @(negedge clk);
    end
    #1 lk_req_valid = 1'b0;
    while (acc && !seen && lat < 300) begin
      @(posedge clk); lat++;
      @(negedge clk); seen = lk_rsp_valid;
    end
    timeout = !seen;
    idx = int'(lk_rsp_idx); nw = lk_rsp_new; full = lk_rsp_full;
  endtask

  task automatic dut_mgmt(input bit op, input logic [HL-1:0] addr,
                          output bit hit, output logic [KW-1:0] key,
                          output int lat, output bit timeout);
    bit acc;
    bit seen;
    int g;
    acc = 0; seen = 0; g = 0; lat = 0;
    @(negedge clk);
    mg_req_valid = 1'b1; mg_op = op; mg_addr = addr;
    while (!acc && g < 300) begin
      #1; acc = mg_req_ready;
      @(posedge clk); g++;
      if (!acc) @(negedge clk);
    end
    #1 mg_req_valid = 1'b0;
    while (acc && !seen && lat < 300) begin
      @(posedge clk); lat++;
      @(negedge clk); seen = mg_rsp_valid;
    end
    timeout = !seen;
    hit = mg_rsp_hit; key = mg_rsp_key;
  endtask

  task automatic do_reset();
    int e;
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    e = 0;
    while (!init_done && e < 100) begin @(posedge clk); e++; @(negedge clk); end
    checks++;
    if (init_done !== 1'b1) begin
      errors++; $display("FAIL reset_reinit: init_done=%0b after %0d cycles, required 1", init_done, e);
    end
    model_clear();
  endtask

  task automatic test_reset();
    int e;
    bit bad_ready;
    bit bad_rsp;
    repeat (3) @(negedge clk);
    checks++;
    if ({lk_req_ready, mg_req_ready, lk_rsp_valid, lk_rsp_new, lk_rsp_full, mg_rsp_valid,
         mg_rsp_hit, init_done} !== 8'h00 || lk_rsp_idx !== '0 || mg_rsp_key !== '0) begin
      errors++; $display("FAIL reset_outputs: some output nonzero in reset (rdy=%0b%0b done=%0b)",
                         lk_req_ready, mg_req_ready, init_done);
    end
    lk_req_valid = 1'b1; mg_req_valid = 1'b1;
    reset = 1'b1;
    e = 0; bad_ready = 0; bad_rsp = 0;
    while (!init_done && e < 100) begin
      @(posedge clk); e++;
      @(negedge clk);
      if (!init_done && (lk_req_ready || mg_req_ready)) bad_ready = 1;
      if (lk_rsp_valid || mg_rsp_valid) bad_rsp = 1;
    end
    lk_req_valid = 1'b0; mg_req_valid = 1'b0;
    checks++;
    if (e !== 64 || init_done !== 1'b1) begin
      errors++; $display("FAIL init_latency: init_done=%0b after %0d cycles, required 1 after 64", init_done, e);
    end
    checks++;
    if (bad_ready || bad_rsp) begin
      errors++; $display("FAIL init_quiet: ready_seen=%0b rsp_seen=%0b during sweep, required 0 0", bad_ready, bad_rsp);
    end
    model_clear();
  endtask

  task automatic test_basic();
    logic [KW-1:0] k1;
    int idx, lat, e_idx, e_p;
    bit nw, full, to, e_nw, e_full;
    k1 = rand_key();
    for (int rep = 0; rep < 2; rep++) begin
      model_lookup(k1, 5, e_idx, e_nw, e_full, e_p);
      dut_lookup(k1, 6'd5, idx, nw, full, lat, to);
      checks++;
      if (to || idx !== e_idx || nw !== e_nw || full !== e_full || lat !== e_p) begin
        errors++; $display("FAIL basic_k1_%0d: idx=%0d new=%0b full=%0b lat=%0d to=%0b, required idx=%0d new=%0b full=%0b lat=%0d",
                           rep, idx, nw, full, lat, to, e_idx, e_nw, e_full, e_p);
      end
    end
    @(negedge clk);
    checks++;
    if (lk_rsp_valid !== 1'b0 || lk_rsp_idx !== 6'd5) begin
      errors++; $display("FAIL rsp_pulse: valid=%0b idx=%0d one cycle later, required 0 and held 5", lk_rsp_valid, lk_rsp_idx);
    end
  endtask

  task automatic test_wrap_tomb();
    logic [KW-1:0] k2, k3, key, e_key;
    int idx, lat, e_idx, e_p;
    bit nw, full, to, e_nw, e_full, hit, e_hit;
    k2 = rand_key(); k3 = rand_key();
    for (int s = 0; s < 2; s++) begin
      model_lookup(s == 0 ? k2 : k3, 63, e_idx, e_nw, e_full, e_p);
      dut_lookup(s == 0 ? k2 : k3, 6'd63, idx, nw, full, lat, to);
      checks++;
      if (to || idx !== e_idx || nw !== e_nw || full !== e_full || lat !== e_p || idx !== (s == 0 ? 63 : 0)) begin
        errors++; $display("FAIL wrap_insert_%0d: idx=%0d new=%0b lat=%0d to=%0b, required idx=%0d new=%0b lat=%0d",
                           s, idx, nw, lat, to, e_idx, e_nw, e_p);
      end
    end
    model_mgmt(1'b1, 63, e_hit, e_key);
    dut_mgmt(1'b1, 6'd63, hit, key, lat, to);
    checks++;
    if (to || hit !== e_hit || key !== e_key || lat !== 1 || key !== k2) begin
      errors++; $display("FAIL delete63: hit=%0b key=%h lat=%0d to=%0b, required hit=%0b key=%h lat=1",
                         hit, key, lat, to, e_hit, e_key);
    end
    model_lookup(k3, 63, e_idx, e_nw, e_full, e_p);
    dut_lookup(k3, 6'd63, idx, nw, full, lat, to);
    checks++;
    if (to || idx !== e_idx || nw !== e_nw || full !== e_full || lat !== e_p || idx !== 0) begin
      errors++; $display("FAIL skip_tomb: idx=%0d new=%0b lat=%0d to=%0b, required idx=%0d new=%0b lat=%0d",
                         idx, nw, lat, to, e_idx, e_nw, e_p);
    end
    model_mgmt(1'b1, 63, e_hit, e_key);
    dut_mgmt(1'b1, 6'd63, hit, key, lat, to);
    checks++;
    if (to || hit !== e_hit || key !== e_key) begin
      errors++; $display("FAIL delete_tomb: hit=%0b key=%h to=%0b, required hit=%0b key=%h", hit, key, to, e_hit, e_key);
    end
  endtask

  task automatic test_random();
    logic [KW-1:0] pool [8];
    logic [KW-1:0] k, key, e_key;
    logic [HL-1:0] h;
    int idx, lat, e_idx, e_p, r;
    bit nw, full, to, e_nw, e_full, hit, e_hit, op;
    for (int i = 0; i < 8; i++) pool[i] = rand_key();
    pool[0] = '0;
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      h = 6'((60 + $urandom_range(0, 7)) % N);
      if (r < 6) begin
        k = pool[$urandom_range(0, 7)];
        model_lookup(k, int'(h), e_idx, e_nw, e_full, e_p);
        dut_lookup(k, h, idx, nw, full, lat, to);
        checks++;
        if (to || idx !== e_idx || nw !== e_nw || full !== e_full || lat !== e_p) begin
          errors++; $display("FAIL rand_lookup_%0d: idx=%0d new=%0b full=%0b lat=%0d to=%0b, required idx=%0d new=%0b full=%0b lat=%0d",
                             n, idx, nw, full, lat, to, e_idx, e_nw, e_full, e_p);
        end
      end else begin
        op = (r < 8);
        model_mgmt(op, int'(h), e_hit, e_key);
        dut_mgmt(op, h, hit, key, lat, to);
        checks++;
        if (to || hit !== e_hit || key !== e_key || lat !== 1) begin
          errors++; $display("FAIL rand_mgmt_%0d: op=%0b hit=%0b key=%h lat=%0d to=%0b, required hit=%0b key=%h lat=1",
                             n, op, hit, key, lat, to, e_hit, e_key);
        end
      end
    end
  endtask

  task automatic test_arbitration();
    bit g_lk [4];
    int g_edge [4];
    int gcount, cyc;
    bit lr, mr, both_err;
    do_reset();
    gcount = 0; cyc = 0; both_err = 0;
    @(negedge clk);
    lk_req_valid = 1'b1; lk_key = rand_key(); lk_hash = 6'd10;
    mg_req_valid = 1'b1; mg_op = 1'b0; mg_addr = 6'd3;
    while (gcount < 4 && cyc < 100) begin
      #1; lr = lk_req_ready; mr = mg_req_ready;
      if (lr && mr) both_err = 1;
      @(posedge clk); cyc++;
      if (lr || mr) begin
        g_lk[gcount] = lr; g_edge[gcount] = cyc; gcount++;
      end
      if (gcount == 4) begin
        #1; lk_req_valid = 1'b0; mg_req_valid = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    lk_req_valid = 1'b0; mg_req_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (gcount !== 4 || both_err) begin
      errors++; $display("FAIL arb_grants: %0d grants both_ready=%0b, required 4 grants and one ready", gcount, both_err);
    end
    for (int i = 0; i < 4 && i < gcount; i++) begin
      checks++;
      if (g_lk[i] !== (i % 2 == 0)) begin
        errors++; $display("FAIL arb_order_%0d: granted %s, required %s", i, g_lk[i] ? "lk" : "mg", (i % 2 == 0) ? "lk" : "mg");
      end
      if (i > 0) begin
        checks++;
        if (g_edge[i] - g_edge[i-1] !== 2) begin
          errors++; $display("FAIL arb_gap_%0d: %0d cycles between grants, required 2", i, g_edge[i] - g_edge[i-1]);
        end
      end
    end
  endtask

  task automatic test_full();
    logic [KW-1:0] k, key, e_key;
    logic [HL-1:0] h;
    int idx, lat, e_idx, e_p, bad;
    bit nw, full, to, e_nw, e_full, hit, e_hit;
    do_reset();
    bad = 0;
    for (int i = 0; i < N; i++) begin
      k = (i == 0) ? '0 : {32'(i), $urandom, $urandom, 8'h11};
      h = 6'($urandom_range(0, N - 1));
      model_lookup(k, int'(h), e_idx, e_nw, e_full, e_p);
      dut_lookup(k, h, idx, nw, full, lat, to);
      if (to || idx !== e_idx || nw !== e_nw || full !== e_full || lat !== e_p) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL fill_table: %0d of 64 inserts differ from model, required 0", bad);
    end
    k = {32'hFFFF_FFFF, $urandom, $urandom, 8'h22};
    model_lookup(k, 9, e_idx, e_nw, e_full, e_p);
    dut_lookup(k, 6'd9, idx, nw, full, lat, to);
    checks++;
    if (to || full !== 1'b1 || idx !== 0 || nw !== 1'b0 || lat !== 64 || e_full !== 1'b1) begin
      errors++; $display("FAIL table_full: full=%0b idx=%0d new=%0b lat=%0d to=%0b, required full=1 idx=0 new=0 lat=64",
                         full, idx, nw, lat, to);
    end
    model_lookup(48'h0, 0, e_idx, e_nw, e_full, e_p);
    dut_lookup('0, 6'd0, idx, nw, full, lat, to);
    checks++;
    if (to || idx !== e_idx || nw !== 1'b0 || full !== 1'b0 || lat !== e_p) begin
      errors++; $display("FAIL zero_key_hit: idx=%0d new=%0b full=%0b lat=%0d, required idx=%0d new=0 full=0 lat=%0d",
                         idx, nw, full, lat, e_idx, e_p);
    end
    model_mgmt(1'b1, 7, e_hit, e_key);
    dut_mgmt(1'b1, 6'd7, hit, key, lat, to);
    checks++;
    if (to || hit !== 1'b1 || key !== e_key) begin
      errors++; $display("FAIL full_delete7: hit=%0b key=%h, required hit=1 key=%h", hit, key, e_key);
    end
    for (int s = 0; s < 2; s++) begin
      model_lookup(k, 3, e_idx, e_nw, e_full, e_p);
      dut_lookup(k, 6'd3, idx, nw, full, lat, to);
      checks++;
      if (to || idx !== e_idx || nw !== e_nw || full !== e_full || lat !== e_p || idx !== 7) begin
        errors++; $display("FAIL tomb_reuse_%0d: idx=%0d new=%0b full=%0b lat=%0d to=%0b, required idx=%0d new=%0b full=%0b lat=%0d",
                           s, idx, nw, full, lat, to, e_idx, e_nw, e_full, e_p);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [KW-1:0] key;
    int idx, lat, e, e_idx, e_p, bad;
    bit nw, full, to, e_nw, e_full, hit, seen_rsp, acc;
    do_reset();
    for (int i = 20; i < 29; i++) begin
      model_lookup(rand_key() ^ KW'(i), i, e_idx, e_nw, e_full, e_p);
      dut_lookup(m_key[e_idx], 6'(i), idx, nw, full, lat, to);
    end
    checks++;
    if (m_st[28] !== 1 || m_st[29] !== 0) begin
      errors++; $display("FAIL mid_setup: model slots 28/29 = %0d/%0d, required 1/0", m_st[28], m_st[29]);
    end
    seen_rsp = 0;
    @(negedge clk);
    lk_req_valid = 1'b1; lk_key = rand_key(); lk_hash = 6'd20;
    #1 acc = lk_req_ready;
    @(posedge clk);
    #1 lk_req_valid = 1'b0;
    checks++;
    if (acc !== 1'b1) begin
      errors++; $display("FAIL mid_accept: ready=%0b, required 1", acc);
    end
    repeat (5) begin @(negedge clk); if (lk_rsp_valid) seen_rsp = 1; end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (init_done !== 1'b0 || lk_rsp_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset_now: init_done=%0b rsp=%0b, required 0 0", init_done, lk_rsp_valid);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    e = 0;
    while (!init_done && e < 100) begin
      @(posedge clk); e++;
      @(negedge clk);
      if (lk_rsp_valid || mg_rsp_valid) seen_rsp = 1;
    end
    checks++;
    if (seen_rsp || e !== 64) begin
      errors++; $display("FAIL mid_no_rsp: rsp_seen=%0b resweep=%0d cycles, required 0 and 64", seen_rsp, e);
    end
    model_clear();
    bad = 0;
    for (int a = 0; a < N; a++) begin
      dut_mgmt(1'b0, 6'(a), hit, key, lat, to);
      if (to || hit !== 1'b0 || key !== '0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL resweep_empty: %0d slots not empty, required 0", bad);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_wrap_tomb();
    test_random();
    test_arbitration();
    test_full();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
